// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle MIPS core: combinational read, clocked store, synchronous clear.
// Optional store trace enabled by defining DM_WRITE_LOG_EN.
module data_memory #(
  parameter int DEPTH = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [31:0] instr,
  input  logic        MemWrite,
  output logic [31:0] read_data
);

  localparam int IDX_W = 12;

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             wr_en;

  // Power-up contents are all zero; reset clears them again at run time.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  always_comb begin
    idx       = addr[13:2];
    in_range  = ({{(32-IDX_W){1'b0}}, idx} < 32'(DEPTH));
    wr_en     = MemWrite && in_range;
    read_data = in_range ? mem_q[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= write_data;
`ifdef DM_WRITE_LOG_EN
      $display("@%08h: *%08h <= %08h", instr, {addr[31:2], 2'b00}, write_data);
`endif
    end
  end

  // Upper and byte-offset address bits never select a word.
`ifdef DM_WRITE_LOG_EN
  logic unused_bits;
  assign unused_bits = ^{addr[31:14], addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{instr, addr[31:14], addr[1:0]};
`endif

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, then random traffic against a sparse word-array model.
module tb_data_memory;

  localparam int DEPTH = 3072;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] instr;
  logic        MemWrite;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .write_data(write_data),
    .instr     (instr),
    .MemWrite  (MemWrite),
    .read_data (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] pc;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t vecs [$];

  // Reference: words keyed by index; absent entries read as zero.
  logic [31:0] model [int];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int ix;
    ix = int'((a >> 2) & 32'hFFF);
    if (ix < DEPTH && model.exists(ix)) return model[ix];
    return 32'h0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle: check the pre-edge value (no bypass), then the post-edge value.
  task automatic apply(input string nm, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pc,
                       input logic [31:0] pre, input logic [31:0] post);
    reset = r; MemWrite = w; addr = a; write_data = d; instr = pc;
    #1 check({nm, "_pre"}, read_data, pre);
    @(posedge clk);
    #1 check({nm, "_post"}, read_data, post);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; write_data = '0; instr = '0;

    // Power-up contents read as zero before any edge.
    addr = 32'h8;
    #1 check("pwrup_0x8", read_data, 32'h0);
    addr = 32'h2FFC;
    #1 check("pwrup_0x2ffc", read_data, 32'h0);

    //            name          rst   we    addr           data           pc             pre            post
    vecs.push_back('{"store4",    1'b0, 1'b1, 32'h0000_0004, 32'h0000_1234, 32'h0000_3004, 32'h0,         32'h0000_1234});
    vecs.push_back('{"load4",     1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_3008, 32'h0000_1234, 32'h0000_1234});
    vecs.push_back('{"store10",   1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_300C, 32'h0,         32'hDEAD_BEEF});
    vecs.push_back('{"rst_beats", 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0005, 32'h0000_3010, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{"rst_clr4",  1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_3014, 32'h0,         32'h0});
    vecs.push_back('{"misalign",  1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0000_3018, 32'h0,         32'hCAFE_F00D});
    vecs.push_back('{"align_rd",  1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_301C, 32'hCAFE_F00D, 32'hCAFE_F00D});
    vecs.push_back('{"store0",    1'b0, 1'b1, 32'h0000_0000, 32'h0000_0077, 32'h0000_3020, 32'h0,         32'h0000_0077});
    vecs.push_back('{"oor_wr",    1'b0, 1'b1, 32'h0000_3000, 32'h0000_0001, 32'h0000_3024, 32'h0,         32'h0});
    vecs.push_back('{"oor_keep0", 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_3028, 32'h0000_0077, 32'h0000_0077});
    vecs.push_back('{"top_a",     1'b0, 1'b1, 32'h0000_2FFC, 32'h0000_AAAA, 32'h0000_302C, 32'h0,         32'h0000_AAAA});
    vecs.push_back('{"top_b",     1'b0, 1'b1, 32'h0000_2FFC, 32'h0000_BBBB, 32'h0000_3030, 32'h0000_AAAA, 32'h0000_BBBB});
    vecs.push_back('{"hibits",    1'b0, 1'b1, 32'hFFFF_C004, 32'h0000_0055, 32'h0000_3034, 32'h0,         32'h0000_0055});
    vecs.push_back('{"hibits_rd", 1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_3038, 32'h0000_0055, 32'h0000_0055});

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].rst, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].pc,
            vecs[i].exp_pre, vecs[i].exp_post);

    // Random traffic; the first cycle resets so the model starts empty.
    for (int i = 0; i < 400; i++) begin
      logic        r, w;
      logic [31:0] a, d, pre, post;
      int          ix;
      r = (i == 0) || ($urandom_range(0, 29) == 0);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ix = int'($urandom_range(0, 15));
        1:       ix = int'($urandom_range(DEPTH - 12, DEPTH - 1));
        2:       ix = int'($urandom_range(DEPTH, 4095));
        default: ix = int'($urandom_range(0, 4095));
      endcase
      a = $urandom();
      a[13:2] = ix[11:0];
      d = $urandom();
      pre = model_read(a);
      if (r) model.delete();
      else if (w && ix < DEPTH) model[ix] = d;
      post = model_read(a);
      apply("rand", r, w, a, d, 32'h0000_4000 + 32'(i * 4), pre, post);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
